// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared UART types and constants (FSM encoding, data width, default depth)
package uart_tx_fifo_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   localparam int UART_DATA_W = 8;
   localparam int DEPTH_LOG2_DEF = 4;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CSR write side and transceiver handshake of the TX FIFO
interface uart_tx_fifo_if import uart_tx_fifo_pkg::*; #(parameter int depth_log2 = DEPTH_LOG2_DEF) ();
   logic [UART_DATA_W-1:0] wr_data;
   logic wr_en;
   logic full;
   logic empty;
   logic [depth_log2:0] level;
   logic ovf;
   logic ovf_clr;
   logic [UART_DATA_W-1:0] tx_data;
   logic tx_wr;
   logic tx_done;
   logic low_event;
   modport master (
      output wr_data, wr_en, ovf_clr, tx_done,
      input full, empty, level, ovf, tx_data, tx_wr, low_event
   );
   modport slave (
      input wr_data, wr_en, ovf_clr, tx_done,
      output full, empty, level, ovf, tx_data, tx_wr, low_event
   );
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: dual-pointer byte RAM, synchronous write, read data registered on pop
module uart_fifo_mem import uart_tx_fifo_pkg::*; #(
   parameter int aw = DEPTH_LOG2_DEF,
   parameter int dw = UART_DATA_W
) (
   input  logic clk,
   input  logic rst,
   input  logic we,
   input  logic [aw-1:0] wptr,
   input  logic [dw-1:0] wdata,
   input  logic re,
   input  logic [aw-1:0] rptr,
   output logic [dw-1:0] rdata
);
   logic [dw-1:0] mem [2**aw];
   // storage write port, contents are not reset
   always_ff @(posedge clk)
      if (we) mem[wptr] <= wdata;
   // read register holds the popped byte until the next pop
   always_ff @(posedge clk or posedge rst)
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[rptr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transceiver; define UART_TX_FIFO_LOWMARK_EN for the low-level event
module uart_tx_fifo import uart_tx_fifo_pkg::*; #(
   parameter int depth_log2 = DEPTH_LOG2_DEF,
   parameter int low_mark = 2
) (
   input logic sys_clk,
   input logic sys_rst,
   uart_tx_fifo_if.slave bus
);
   localparam int lw = depth_log2 + 1;
   localparam logic [lw-1:0] full_lvl = lw'(1) << depth_log2;
   if (depth_log2 < 1 || depth_log2 > 8 || low_mark < 0 || low_mark >= 2**depth_log2) begin : g_bad_cfg
      $error("uart_tx_fifo: depth_log2 or low_mark out of range");
   end
   state_t state, state_nxt;
   logic [depth_log2-1:0] wptr, rptr;
   logic [lw-1:0] level, level_nxt;
   logic push, pop, drop, tx_wr, ovf;
   // push/pop decode, next level and next FSM state
   always_comb begin
      push = bus.wr_en && !bus.full;
      drop = bus.wr_en && bus.full;
      pop = (level != '0) && (state == IDLE || bus.tx_done);
      level_nxt = level + lw'(push) - lw'(pop);
      state_nxt = pop ? BUSY : (bus.tx_done ? IDLE : state);
   end
   // FSM state register
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) state <= IDLE;
      else state <= state_nxt;
   // pointers, level, start pulse and sticky overflow
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         wptr <= '0;
         rptr <= '0;
         level <= '0;
         tx_wr <= 1'b0;
         ovf <= 1'b0;
      end else begin
         wptr <= push ? wptr + depth_log2'(1) : wptr;
         rptr <= pop ? rptr + depth_log2'(1) : rptr;
         level <= level_nxt;
         tx_wr <= pop;
         ovf <= drop || (ovf && !bus.ovf_clr);
      end
   uart_fifo_mem #(.aw(depth_log2), .dw(UART_DATA_W)) u_mem (
      .clk(sys_clk),
      .rst(sys_rst),
      .we(push),
      .wptr(wptr),
      .wdata(bus.wr_data),
      .re(pop),
      .rptr(rptr),
      .rdata(bus.tx_data)
   );
   assign bus.full = (level == full_lvl);
   assign bus.empty = (level == '0) && (state == IDLE);
   assign bus.level = level;
   assign bus.tx_wr = tx_wr;
   assign bus.ovf = ovf;
`ifdef UART_TX_FIFO_LOWMARK_EN
   localparam logic [lw-1:0] mark = lw'(low_mark);
   logic low_q;
   // pulse when the level drops across the watermark
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) low_q <= 1'b0;
      else low_q <= (level > mark) && (level_nxt <= mark);
   assign bus.low_event = low_q;
`else
   assign bus.low_event = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (depth 16, low_mark 2)
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int passes = 0;
   int total = 0;
   logic [4:0] ev;
   uart_tx_fifo_if #(.depth_log2(4)) bus ();
   uart_tx_fifo #(.depth_log2(4), .low_mark(2)) dut (
      .sys_clk(clk),
      .sys_rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask
   initial begin
`ifdef UART_TX_FIFO_LOWMARK_EN
      ev = 5'b00100;
`else
      ev = 5'b00000;
`endif
      bus.wr_data = 8'h00;
      bus.wr_en = 1'b0;
      bus.ovf_clr = 1'b0;
      bus.tx_done = 1'b0;
      tick;
      tick;
      chk("rst_level", bus.level, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_tx_wr", bus.tx_wr, 0);
      chk("rst_low_event", bus.low_event, 0);
      rst = 1'b0;
      tick;
      // single byte
      bus.wr_data = 8'hA5;
      bus.wr_en = 1'b1;
      tick;
      bus.wr_en = 1'b0;
      chk("single_level1", bus.level, 1);
      chk("single_empty0", bus.empty, 0);
      chk("single_no_wr_yet", bus.tx_wr, 0);
      tick;
      chk("single_tx_wr", bus.tx_wr, 1);
      chk("single_tx_data", bus.tx_data, 8'hA5);
      chk("single_level0", bus.level, 0);
      chk("single_busy_empty0", bus.empty, 0);
      tick;
      chk("single_tx_wr_once", bus.tx_wr, 0);
      repeat (3) tick;
      chk("single_hold_data", bus.tx_data, 8'hA5);
      chk("single_hold_empty0", bus.empty, 0);
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("single_done_empty", bus.empty, 1);
      chk("single_done_tx_wr", bus.tx_wr, 0);
      // burst: one byte in flight, then 16 queued
      bus.wr_data = 8'hEE;
      bus.wr_en = 1'b1;
      tick;
      bus.wr_en = 1'b0;
      tick;
      chk("burst_first_wr", bus.tx_wr, 1);
      chk("burst_first_data", bus.tx_data, 8'hEE);
      for (int i = 0; i < 16; i++) begin
         bus.wr_data = 8'(i);
         bus.wr_en = 1'b1;
         tick;
      end
      bus.wr_en = 1'b0;
      chk("burst_level16", bus.level, 16);
      chk("burst_full", bus.full, 1);
      chk("burst_ovf0", bus.ovf, 0);
      // overflow
      bus.wr_data = 8'hFF;
      bus.wr_en = 1'b1;
      tick;
      bus.wr_en = 1'b0;
      chk("ovf_set", bus.ovf, 1);
      chk("ovf_level16", bus.level, 16);
      bus.ovf_clr = 1'b1;
      tick;
      bus.ovf_clr = 1'b0;
      chk("ovf_clr", bus.ovf, 0);
      bus.wr_en = 1'b1;
      bus.ovf_clr = 1'b1;
      tick;
      bus.wr_en = 1'b0;
      bus.ovf_clr = 1'b0;
      chk("ovf_set_wins", bus.ovf, 1);
      chk("ovf_set_wins_level", bus.level, 16);
      // drain with tx_done 10 cycles after each tx_wr
      for (int i = 0; i < 16; i++) begin
         bus.tx_done = 1'b1;
         tick;
         bus.tx_done = 1'b0;
         chk($sformatf("drain_wr_%0d", i), bus.tx_wr, 1);
         chk($sformatf("drain_data_%0d", i), bus.tx_data, i);
         chk($sformatf("drain_level_%0d", i), bus.level, 15 - i);
         tick;
         chk($sformatf("drain_wr_low_%0d", i), bus.tx_wr, 0);
         repeat (8) tick;
      end
      chk("drain_full0", bus.full, 0);
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("drain_empty", bus.empty, 1);
      chk("drain_no_wr", bus.tx_wr, 0);
      // simultaneous push and pop across pointer wrap, 40 bytes
      for (int i = 0; i < 4; i++) begin
         bus.wr_data = 8'(8'h40 + i);
         bus.wr_en = 1'b1;
         tick;
      end
      bus.wr_en = 1'b0;
      chk("pp_level3", bus.level, 3);
      chk("pp_first_data", bus.tx_data, 8'h40);
      for (int k = 0; k < 36; k++) begin
         bus.wr_data = 8'(8'h44 + k);
         bus.wr_en = 1'b1;
         bus.tx_done = 1'b1;
         tick;
         bus.wr_en = 1'b0;
         bus.tx_done = 1'b0;
         chk($sformatf("pp_level_%0d", k), bus.level, 3);
         chk($sformatf("pp_wr_%0d", k), bus.tx_wr, 1);
         chk($sformatf("pp_data_%0d", k), bus.tx_data, 8'h41 + k);
         tick;
      end
      for (int j = 0; j < 3; j++) begin
         bus.tx_done = 1'b1;
         tick;
         bus.tx_done = 1'b0;
         chk($sformatf("pp_tail_data_%0d", j), bus.tx_data, 8'h65 + j);
         tick;
      end
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("pp_empty", bus.empty, 1);
      // async reset mid-frame
      bus.wr_data = 8'h5A;
      bus.wr_en = 1'b1;
      tick;
      bus.wr_en = 1'b0;
      tick;
      chk("ar_tx_wr", bus.tx_wr, 1);
      chk("ar_ovf_sticky", bus.ovf, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_level", bus.level, 0);
      chk("ar_empty", bus.empty, 1);
      chk("ar_tx_wr0", bus.tx_wr, 0);
      chk("ar_ovf0", bus.ovf, 0);
      chk("ar_tx_data", bus.tx_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      tick;
      bus.wr_data = 8'h3C;
      bus.wr_en = 1'b1;
      tick;
      bus.wr_en = 1'b0;
      tick;
      chk("ar_after_wr", bus.tx_wr, 1);
      chk("ar_after_data", bus.tx_data, 8'h3C);
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("ar_after_empty", bus.empty, 1);
      // watermark: fill to 5 behind a byte in flight, then drain
      for (int i = 0; i < 6; i++) begin
         bus.wr_data = 8'(8'h70 + i);
         bus.wr_en = 1'b1;
         tick;
         chk($sformatf("wm_fill_ev_%0d", i), bus.low_event, 0);
      end
      bus.wr_en = 1'b0;
      chk("wm_level5", bus.level, 5);
      for (int i = 0; i < 5; i++) begin
         bus.tx_done = 1'b1;
         tick;
         bus.tx_done = 1'b0;
         chk($sformatf("wm_level_%0d", i), bus.level, 4 - i);
         chk($sformatf("wm_data_%0d", i), bus.tx_data, 8'h71 + i);
         chk($sformatf("wm_ev_%0d", i), bus.low_event, ev[i]);
         tick;
         chk($sformatf("wm_ev_off_%0d", i), bus.low_event, 0);
      end
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("wm_empty", bus.empty, 1);
      chk("wm_ev_end", bus.low_event, 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
